// File: rtl/dp_sram_pkg.sv
// Shared types and helpers for the parametrised dual-port SRAM model.
package dp_sram_pkg;

    typedef enum logic [1:0] {
        StActive,
        StNap,
        StWake
    } pwr_state_e;

    localparam int unsigned RdLatMin = 1;
    localparam int unsigned RdLatMax = 2;

    // Wide enough for WAKE_CYC up to 15.
    localparam int unsigned WakeCntW = 4;

    function automatic logic [7:0] byte_merge(
        logic [7:0] old_b,
        logic [7:0] new_b,
        logic       bwe_n
    );
        return bwe_n ? old_b : new_b;
    endfunction

endpackage

// File: rtl/dp_sram_rdpipe.sv
// Read-data output pipeline: one or two register stages, holding when idle.
module dp_sram_rdpipe
    import dp_sram_pkg::*;
#(
    parameter int unsigned W   = 32,
    parameter int unsigned LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    if (LAT >= RdLatMax) begin : g_two
        logic         v1_q;
        logic [W-1:0] d1_q;
        logic [W-1:0] d2_q;

        // Stage 2 only advances behind a real load so the output holds otherwise.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v1_q <= 1'b0;
                d1_q <= '0;
                d2_q <= '0;
            end else begin
                v1_q <= ld;
                if (ld) begin
                    d1_q <= din;
                end
                if (v1_q) begin
                    d2_q <= d1_q;
                end
            end
        end

        assign dout = d2_q;
    end else begin : g_one
        logic [W-1:0] d1_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d1_q <= '0;
            end else if (ld) begin
                d1_q <= din;
            end
        end

        assign dout = d1_q;
    end

endmodule

// File: rtl/dp_sram_model.sv
// Cycle-accurate true dual-port synchronous SRAM model with byte enables,
// selectable read latency, collision handling and a nap/wake power FSM.
module dp_sram_model
    import dp_sram_pkg::*;
#(
    parameter int unsigned DW       = 32,
    parameter int unsigned DEPTH    = 8192,
    parameter int unsigned AW       = $clog2(DEPTH),
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned WAKE_CYC = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            csan,
    input  logic            wean,
    input  logic [DW/8-1:0] bwean,
    input  logic [AW-1:0]   a,
    input  logic [DW-1:0]   dia,
    output logic [DW-1:0]   doa,
    input  logic            csbn,
    input  logic            webn,
    input  logic [DW/8-1:0] bwebn,
    input  logic [AW-1:0]   b,
    input  logic [DW-1:0]   dib,
    output logic [DW-1:0]   dob,
    input  logic            nap,
    output logic            ready,
    output logic            coll,
    output logic            err
);

    localparam int unsigned NB  = DW / 8;
    localparam int unsigned Lat = (RD_LAT <= RdLatMin) ? RdLatMin : RdLatMax;

    function automatic logic [DW-1:0] word_merge(
        logic [DW-1:0] old_w,
        logic [DW-1:0] new_w,
        logic [NB-1:0] bwe_n
    );
        logic [DW-1:0] res;
        for (int i = 0; i < NB; i++) begin
            res[8*i +: 8] = byte_merge(old_w[8*i +: 8], new_w[8*i +: 8], bwe_n[i]);
        end
        return res;
    endfunction

    // Array has no reset: contents survive rst_n.
    logic [DW-1:0] mem [DEPTH];

    pwr_state_e          state_q, state_d;
    logic [WakeCntW-1:0] cnt_q, cnt_d;
    logic                active;

    logic          in_a, in_b;
    logic          ena, enb, wr_a, wr_b, same;
    logic [DW-1:0] old_a, old_b, only_b, fin_a, fin_b, rd_a, rd_b;
    logic          coll_d, err_d, coll_q, err_q;

    if (DEPTH == (2 ** AW)) begin : g_full
        assign in_a = 1'b1;
        assign in_b = 1'b1;
    end else begin : g_part
        assign in_a = (a < AW'(DEPTH));
        assign in_b = (b < AW'(DEPTH));
    end

    // Power FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StActive;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Power FSM: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StActive: begin
                if (nap) begin
                    state_d = StNap;
                end
            end
            StNap: begin
                if (!nap) begin
                    state_d = StWake;
                    cnt_d   = WakeCntW'(WAKE_CYC - 1);
                end
            end
            StWake: begin
                if (nap) begin
                    state_d = StNap;
                end else if (cnt_q == '0) begin
                    state_d = StActive;
                end else begin
                    cnt_d = cnt_q - WakeCntW'(1);
                end
            end
            default: state_d = StActive;
        endcase
    end

    // Power FSM: outputs
    always_comb begin
        active = (state_q == StActive);
        ready  = active;
    end

    always_comb begin
        ena    = !csan && active;
        enb    = !csbn && active;
        wr_a   = ena && in_a && !wean;
        wr_b   = enb && in_b && !webn;
        same   = ena && enb && in_a && in_b && (a == b);
        old_a  = mem[a];
        old_b  = mem[b];
        only_b = word_merge(old_b, dib, bwebn);
        // On a shared address B's bytes land first and A's enabled bytes override.
        fin_a  = word_merge((same && wr_b) ? only_b : old_a, dia, bwean);
        fin_b  = (same && wr_a) ? fin_a : only_b;
        rd_a   = !in_a ? '0 : (wr_a ? fin_a : old_a);
        rd_b   = !in_b ? '0 : (wr_b ? fin_b : old_b);
        coll_d = same && (wr_a || wr_b);
        err_d  = (!active && (!csan || !csbn)) || (ena && !in_a) || (enb && !in_b);
    end

    always_ff @(posedge clk) begin
        if (wr_b) begin
            mem[b] <= fin_b;
        end
        if (wr_a) begin
            mem[a] <= fin_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            coll_q <= coll_d;
            err_q  <= err_d;
        end
    end

    assign coll = coll_q;
    assign err  = err_q;

    dp_sram_rdpipe #(
        .W  (DW),
        .LAT(Lat)
    ) u_pipe_a (
        .clk  (clk),
        .rst_n(rst_n),
        .ld   (ena),
        .din  (rd_a),
        .dout (doa)
    );

    dp_sram_rdpipe #(
        .W  (DW),
        .LAT(Lat)
    ) u_pipe_b (
        .clk  (clk),
        .rst_n(rst_n),
        .ld   (enb),
        .din  (rd_b),
        .dout (dob)
    );

endmodule

// File: tb/tb_dp_sram_model.sv
// Scoreboard bench for dp_sram_model: directed scenarios then randomized traffic
// against an array-based reference model.
module tb_dp_sram_model;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1000;
    localparam int unsigned AW    = 10;
    localparam int unsigned LAT   = 2;
    localparam int unsigned WAKE  = 4;
    localparam int unsigned NB    = DW / 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          csan  = 1'b1;
    logic          wean  = 1'b1;
    logic [NB-1:0] bwean = '1;
    logic [AW-1:0] a     = '0;
    logic [DW-1:0] dia   = '0;
    logic          csbn  = 1'b1;
    logic          webn  = 1'b1;
    logic [NB-1:0] bwebn = '1;
    logic [AW-1:0] b     = '0;
    logic [DW-1:0] dib   = '0;
    logic          nap   = 1'b0;
    logic [DW-1:0] doa, dob;
    logic          ready, coll, err;

    dp_sram_model #(
        .DW      (DW),
        .DEPTH   (DEPTH),
        .AW      (AW),
        .RD_LAT  (LAT),
        .WAKE_CYC(WAKE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .csan (csan),
        .wean (wean),
        .bwean(bwean),
        .a    (a),
        .dia  (dia),
        .doa  (doa),
        .csbn (csbn),
        .webn (webn),
        .bwebn(bwebn),
        .b    (b),
        .dib  (dib),
        .dob  (dob),
        .nap  (nap),
        .ready(ready),
        .coll (coll),
        .err  (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] val;
    } dexp_t;

    typedef struct {
        int   due;
        logic c;
        logic e;
        logic r;
    } fexp_t;

    dexp_t qa[$];
    dexp_t qb[$];
    fexp_t qf[$];

    int            edge_n = 0;
    int            checks = 0;
    int            errors = 0;
    bit            mon_on = 1'b0;
    logic [DW-1:0] exp_a  = '0;
    logic [DW-1:0] exp_b  = '0;

    // Reference model: plain word array and a simple sleep/wake timeline.
    logic [DW-1:0] mm [DEPTH];
    bit            sleeping   = 1'b0;
    int            ready_from = 0;
    int            nap_left   = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_n, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        dexp_t d;
        fexp_t f;
        if (mon_on && rst_n) begin
            while (qa.size() > 0 && qa[0].due <= edge_n) begin
                d = qa.pop_front();
                exp_a = d.val;
            end
            while (qb.size() > 0 && qb[0].due <= edge_n) begin
                d = qb.pop_front();
                exp_b = d.val;
            end
            check("doa", doa, exp_a);
            check("dob", dob, exp_b);
            while (qf.size() > 0 && qf[0].due < edge_n) begin
                f = qf.pop_front();
            end
            if (qf.size() > 0 && qf[0].due == edge_n) begin
                f = qf.pop_front();
                check("coll", DW'(coll), DW'(f.c));
                check("err", DW'(err), DW'(f.e));
                check("ready", DW'(ready), DW'(f.r));
            end
        end
    end

    // Predict the effect of the upcoming edge from the current inputs, then take it.
    task automatic cycle();
        int            e;
        bit            act, ena, enb, ina, inb, wa, wb, same, ex;
        logic [DW-1:0] olda, oldb;
        e    = edge_n + 1;
        act  = !sleeping && (e - 1 >= ready_from);
        ena  = act && !csan;
        enb  = act && !csbn;
        ina  = (a < DEPTH);
        inb  = (b < DEPTH);
        wa   = ena && ina && !wean;
        wb   = enb && inb && !webn;
        same = ena && enb && ina && inb && (a == b);
        ex   = (!act && (!csan || !csbn)) || (ena && !ina) || (enb && !inb);
        olda = ina ? mm[a] : '0;
        oldb = inb ? mm[b] : '0;
        if (wb) begin
            for (int i = 0; i < NB; i++) if (!bwebn[i]) mm[b][8*i +: 8] = dib[8*i +: 8];
        end
        // A goes last so it wins any byte both ports enable on the same word.
        if (wa) begin
            for (int i = 0; i < NB; i++) if (!bwean[i]) mm[a][8*i +: 8] = dia[8*i +: 8];
        end
        if (ena) qa.push_back('{e + LAT - 1, wa ? mm[a] : olda});
        if (enb) qb.push_back('{e + LAT - 1, wb ? mm[b] : oldb});
        if (act) begin
            if (nap) sleeping = 1'b1;
        end else if (sleeping) begin
            if (!nap) begin
                sleeping   = 1'b0;
                ready_from = e + WAKE;
            end
        end else if (nap) begin
            sleeping = 1'b1;
        end
        qf.push_back('{e, same && (wa || wb), ex, !sleeping && (e >= ready_from)});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        csan  = 1'b1;
        csbn  = 1'b1;
        wean  = 1'b1;
        webn  = 1'b1;
        bwean = '1;
        bwebn = '1;
    endtask

    task automatic wr_a(input int adr, input logic [DW-1:0] d, input logic [NB-1:0] be);
        csan  = 1'b0;
        wean  = 1'b0;
        a     = AW'(adr);
        dia   = d;
        bwean = be;
    endtask

    task automatic rd_a(input int adr);
        csan = 1'b0;
        wean = 1'b1;
        a    = AW'(adr);
    endtask

    task automatic wr_b(input int adr, input logic [DW-1:0] d, input logic [NB-1:0] be);
        csbn  = 1'b0;
        webn  = 1'b0;
        b     = AW'(adr);
        dib   = d;
        bwebn = be;
    endtask

    task automatic rd_b(input int adr);
        csbn = 1'b0;
        webn = 1'b1;
        b    = AW'(adr);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        if ($urandom_range(0, 15) == 0) return AW'($urandom_range(DEPTH, 2 ** AW - 1));
        return AW'($urandom_range(0, 15));
    endfunction

    initial begin
        @(posedge clk);
        #1;
        check("rst_doa", doa, '0);
        check("rst_dob", dob, '0);
        check("rst_ready", DW'(ready), DW'(1));
        check("rst_coll", DW'(coll), '0);
        check("rst_err", DW'(err), '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        ready_from = edge_n;
        mon_on     = 1'b1;

        // Preload the low addresses so every later read has a known word.
        for (int i = 0; i < 8; i++) begin
            wr_a(i, $urandom, '0);
            wr_b(i + 8, $urandom, '0);
            cycle();
        end
        idle_ports();

        // Full write then read on the other port.
        wr_a(0, 32'h0000_001A, '0);
        cycle();
        idle_ports();
        rd_b(0);
        cycle();
        idle_ports();

        // Write/write collision: A wins.
        wr_a(1, 32'h1A00_0000, '0);
        wr_b(1, 32'h2B00_0000, '0);
        cycle();
        idle_ports();
        rd_a(1);
        cycle();
        idle_ports();

        // Write/read collision: reader sees the old word.
        wr_a(2, 32'h1111_1111, '0);
        cycle();
        wr_a(2, 32'h2222_2222, '0);
        rd_b(2);
        cycle();
        idle_ports();

        // Partial byte write.
        wr_a(3, 32'h0000_0000, '0);
        cycle();
        wr_a(3, 32'hAABB_CCDD, 4'b1010);
        cycle();
        idle_ports();
        rd_b(3);
        cycle();
        idle_ports();

        // Nap with accesses, then wake and confirm contents.
        nap = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_a(0);
            cycle();
        end
        nap = 1'b0;
        idle_ports();
        for (int i = 0; i < WAKE + 2; i++) begin
            if (i == 1) rd_b(2);
            cycle();
            idle_ports();
        end
        for (int i = 0; i < 4; i++) begin
            rd_a(i);
            rd_b(3 - i);
            cycle();
        end
        idle_ports();

        // Reset with a read still in the pipeline.
        rd_a(1);
        rd_b(2);
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        check("midrst_doa", doa, '0);
        check("midrst_dob", dob, '0);
        check("midrst_ready", DW'(ready), DW'(1));
        qa.delete();
        qb.delete();
        qf.delete();
        exp_a    = '0;
        exp_b    = '0;
        sleeping = 1'b0;
        idle_ports();
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        ready_from = edge_n;
        for (int i = 0; i < 4; i++) begin
            rd_a(i);
            rd_b(i);
            cycle();
        end
        idle_ports();

        // Randomized traffic with occasional naps and out-of-range addresses.
        for (int n = 0; n < 600; n++) begin
            csan  = ($urandom_range(0, 3) == 0);
            csbn  = ($urandom_range(0, 3) == 0);
            wean  = $urandom_range(0, 1) == 1;
            webn  = $urandom_range(0, 1) == 1;
            bwean = NB'($urandom);
            bwebn = NB'($urandom);
            dia   = $urandom;
            dib   = $urandom;
            a     = pick_addr();
            b     = ($urandom_range(0, 3) == 0) ? a : pick_addr();
            if (nap_left > 0) begin
                nap_left--;
                nap = 1'b1;
            end else begin
                nap = 1'b0;
                if ($urandom_range(0, 49) == 0) nap_left = $urandom_range(1, 4);
            end
            cycle();
        end
        nap = 1'b0;
        idle_ports();
        repeat (WAKE + 4) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dp_sram_model.md
Name: dp_sram_model

Overview:
- Parametrised, cycle-accurate behavioural model of a true dual-port synchronous SRAM. It is the generalised successor of the fixed 8192x32 dual-port macro.
- Adds the following over the fixed macro: configurable width and depth, per-byte write enables, selectable read latency, defined same-address collision handling, and a nap/wake power state machine with a wake-up counter.
- Sits between the core logic and the memory macro slot. Benches and RTL simulation use it in place of the hard macro.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- DEPTH, 8192, number of words.
- AW, $clog2(DEPTH), address width.
- RD_LAT, 1, read latency in cycles; legal values are 1 or 2.
- WAKE_CYC, 4, cycles spent in WAKE after nap deasserts; range 1..15.

Ports:
- clk  in  1  single clock shared by ports A and B.
- rst_n  in  1  asynchronous active-low reset.
- csan  in  1  port A chip select, active-low.
- wean  in  1  port A write enable, active-low (0 = write, 1 = read).
- bwean  in  DW/8  port A byte write enable, active-low per byte.
- a  in  AW  port A address.
- dia  in  DW  port A write data.
- doa  out  DW  port A read data.
- csbn, webn, bwebn, b, dib, dob: same as the port A signals, for port B.
- nap  in  1  request for low-power nap.
- ready  out  1  high when the state is ACTIVE.
- coll  out  1  one-cycle pulse on a same-address collision.
- err  out  1  one-cycle pulse on an access attempted while not ACTIVE.

Behaviour:
- Reset (async assert, sync release):
  - doa, dob, coll and err go to 0.
  - State goes to ACTIVE, so ready = 1.
  - Memory array contents are not cleared and are preserved across reset.
- Access: a port accesses the array on the rising clk edge when its cs is low and the state is ACTIVE. Signals are sampled on that edge.
- Read (we=1): array data appears on do RD_LAT cycles after the sampling edge.
  - RD_LAT=1: registered output.
  - RD_LAT=2: one extra pipeline register.
- Write (we=0):
  - Only bytes with bwe[i]=0 are updated.
  - do returns the merged post-write word with the same latency as a read (write-through).
  - bwe all 1 with we=0 makes no array change and returns the current word.
- do holds its last value when there is no access (cs high, or not ACTIVE).
- Collision (same address, both ports selected, same edge, ACTIVE):
  - A write, B write: per byte, port A wins where both enable; each port's do shows the final stored word. coll=1.
  - A write, B read: B returns the old word and A returns the new word. coll=1. B write, A read is the mirror case.
  - Both read: no collision, coll=0.
- Power FSM has three states: ACTIVE, NAP, WAKE.
  - ACTIVE -> NAP when nap=1 is sampled. Accesses sampled on that same edge still complete.
  - NAP -> WAKE when nap=0 is sampled. The wake counter loads WAKE_CYC-1.
  - In WAKE, the counter decrements each cycle. The state goes to ACTIVE on the cycle after the counter reaches 0, so ready rises exactly WAKE_CYC cycles after the nap=0 edge.
  - WAKE -> NAP if nap=1 is sampled.
  - Outside ACTIVE: cs low on either port pulses err for one cycle, the array is untouched, and do holds.
- Pipeline contents already in flight complete normally when the state leaves ACTIVE.
- Reset asserted mid-operation: the in-flight pipeline is discarded and outputs go to 0. A write already captured on an edge before reset stays in the array.
- Out-of-range address (a >= DEPTH when DEPTH is not a power of 2): a write is dropped, a read returns 0, and err pulses.

Decomposition:
- Shared package dp_sram_pkg holds:
  - the power state enum (ACTIVE, NAP, WAKE);
  - the byte-merge function (old, new, bwe_n);
  - the RD_LAT legality constants.
- One sub-module: dp_sram_rdpipe, instantiated once per port. It implements the RD_LAT-stage output register with hold and async clear.

Test Plan:
- Write A@0x0000 dia=0x0000001A with bwean=0 -> doa=0x0000001A after RD_LAT cycles. B read @0x0000 on the next cycle -> dob=0x0000001A.
- Write A@0x0001 dia=0x1A000000, then on the same edge B writes @0x0001 dib=0x2B000000 with all bytes enabled -> coll=1 for one cycle. A later read of 0x0001 returns 0x1A000000.
- Pre-load 0x0002=0x11111111. A writes 0x22222222 while B reads 0x0002 on the same edge -> dob=0x11111111, doa=0x22222222, coll=1.
- A writes @0x0003 dia=0xAABBCCDD with bwean=4'b1010 onto 0x00000000 -> read returns 0x00BB00DD.
- Assert nap for 3 cycles with csan=0 during NAP -> ready=0 and err pulses each access cycle. Deassert nap -> ready=1 exactly WAKE_CYC=4 cycles later, and memory contents are intact.
- Assert rst_n=0 mid-read with RD_LAT=2 -> doa=0 immediately (async). After release, previously written data is still readable.
